// File: rtl/imem_program_encoder.sv
// imem_program_encoder
// Program-load write port for instruction memory. Each request is turned into a
// 32-bit MIPS instruction word and written at the next sequential word address.
// Optional feature: define ENC_MUL_EN to accept kind 5 (MUL) as a legal R-type;
// without it, kind 5 is consumed as an illegal request.
module imem_program_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // count value present during the write that fills the memory
  localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic        enc_legal;
  logic [31:0] enc_word;

  // Ready is gated by RST directly so no request can be taken in a reset cycle.
  assign req_ready = (state == IDLE) && !RST;

  // Encode the current request fields; fields a kind does not use stay zero.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0000_0000;
    case (req_kind)
      4'd0:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100100}; // AND
      4'd1:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100101}; // OR
      4'd2:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000}; // ADD
      4'd3:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010}; // SUB
      4'd4:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b101010}; // SLT
`ifdef ENC_MUL_EN
      4'd5:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b011000}; // MUL
`else
      4'd5:  enc_legal = 1'b0;
`endif
      4'd6:  enc_word = {6'b000000, req_rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000}; // JR
      4'd7:  enc_word = {6'b001000, req_rs, req_rt, req_imm};  // ADDI
      4'd8:  enc_word = {6'b000100, req_rs, req_rt, req_imm};  // BEQ
      4'd9:  enc_word = {6'b101011, req_rs, req_rt, req_imm};  // SW
      4'd10: enc_word = {6'b100011, req_rs, req_rt, req_imm};  // LW
      4'd11: enc_word = {6'b000010, req_target};               // J
      4'd12: enc_word = {6'b000011, req_target};               // JAL
      default: enc_legal = 1'b0;
    endcase
  end

  // Load FSM: accept in IDLE, strobe the write for one cycle, then advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 32'h0000_0000;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (enc_legal) begin
              imem_wd <= enc_word;
              imem_we <= 1'b1;
              state   <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + 1'b1;  // wraps to 0 after the last word
          count     <= count + 1'b1;
          if (count == COUNT_LAST) begin
            state <= FULL;
            full  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_encoder.sv
// tb_imem_program_encoder
// Directed and randomized checks of imem_program_encoder (ADDR_W=2) against a
// table-driven reference encoder and a simple address/count/err model.
// Honors ENC_MUL_EN the same way as the design.
module tb_imem_program_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 2 ** AW;

  logic          CLK;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [4:0]    req_rd;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  imem_program_encoder #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .count(count), .full(full), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_addr;
  int          m_count;
  bit          m_err;
  bit          m_full;
  logic [31:0] last_wd;

  // kind -> format (0 R, 1 R-JR, 2 I, 3 J, 4 illegal) and opcode/funct
  int          fmt_tab  [16];
  logic [5:0]  code_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [32:0] model_enc(input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    bit          ok;
    ok = 1'b1;
    w  = 32'h0;
    case (fmt_tab[k])
      0: w = rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + code_tab[k];
      1: w = rs * (2 ** 21) + code_tab[k];
      2: w = code_tab[k] * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16) + imm;
      3: w = code_tab[k] * (2 ** 26) + tgt;
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Reset with req_valid asserted the whole time: nothing may be accepted.
  task automatic do_reset();
    RST = 1'b1;
    req_valid = 1'b1;
    req_kind = 4'd2; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
    #0;
    check("rst_ready_now", {31'b0, req_ready}, 32'd0);
    repeat (3) begin
      tick();
      check("rst_ready", {31'b0, req_ready}, 32'd0);
    end
    RST = 1'b0;
    req_valid = 1'b0;
    tick();
    m_addr = 0; m_count = 0; m_err = 1'b0; m_full = 1'b0;
    check("post_rst_we",    {31'b0, imem_we}, 32'd0);
    check("post_rst_addr",  {30'b0, imem_addr}, 32'd0);
    check("post_rst_wd",    imem_wd, 32'd0);
    check("post_rst_count", {29'b0, count}, 32'd0);
    check("post_rst_full",  {31'b0, full}, 32'd0);
    check("post_rst_err",   {31'b0, err}, 32'd0);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    logic [32:0] e;
    int          waited;
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e = model_enc(k, rs, rt, rd, imm, tgt);
    tick();
    req_valid = 1'b0;
    // scramble inputs: the accepted word must not depend on them anymore
    req_kind = 4'($urandom); req_rs = 5'($urandom); req_rt = 5'($urandom);
    req_rd = 5'($urandom); req_imm = 16'($urandom); req_target = 26'($urandom);
    if (e[32]) begin
      check("we_write",    {31'b0, imem_we}, 32'd1);
      check("addr_write",  {30'b0, imem_addr}, 32'(m_addr));
      check("wd_write",    imem_wd, e[31:0]);
      check("ready_write", {31'b0, req_ready}, 32'd0);
      last_wd = imem_wd;
      tick();
      m_count++;
      m_addr = (m_addr + 1) % DEPTH;
      m_full = (m_count == DEPTH);
      check("we_after",    {31'b0, imem_we}, 32'd0);
      check("count_after", {29'b0, count}, 32'(m_count));
      check("addr_after",  {30'b0, imem_addr}, 32'(m_addr));
      check("full_after",  {31'b0, full}, {31'b0, m_full});
      check("ready_after", {31'b0, req_ready}, {31'b0, !m_full});
    end else begin
      m_err = 1'b1;
      last_wd = 32'hxxxx_xxxx;
      check("we_illegal",    {31'b0, imem_we}, 32'd0);
      check("count_illegal", {29'b0, count}, 32'(m_count));
      check("ready_illegal", {31'b0, req_ready}, 32'd1);
    end
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  initial begin
    fmt_tab[0] = 0;  code_tab[0] = 6'd36;   // AND
    fmt_tab[1] = 0;  code_tab[1] = 6'd37;   // OR
    fmt_tab[2] = 0;  code_tab[2] = 6'd32;   // ADD
    fmt_tab[3] = 0;  code_tab[3] = 6'd34;   // SUB
    fmt_tab[4] = 0;  code_tab[4] = 6'd42;   // SLT
`ifdef ENC_MUL_EN
    fmt_tab[5] = 0;  code_tab[5] = 6'd24;   // MUL
`else
    fmt_tab[5] = 4;  code_tab[5] = 6'd0;
`endif
    fmt_tab[6] = 1;  code_tab[6] = 6'd8;    // JR
    fmt_tab[7] = 2;  code_tab[7] = 6'd8;    // ADDI
    fmt_tab[8] = 2;  code_tab[8] = 6'd4;    // BEQ
    fmt_tab[9] = 2;  code_tab[9] = 6'd43;   // SW
    fmt_tab[10] = 2; code_tab[10] = 6'd35;  // LW
    fmt_tab[11] = 3; code_tab[11] = 6'd2;   // J
    fmt_tab[12] = 3; code_tab[12] = 6'd3;   // JAL
    for (int i = 13; i < 16; i++) begin
      fmt_tab[i] = 4; code_tab[i] = 6'd0;
    end

    RST = 1'b1; req_valid = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
    m_addr = 0; m_count = 0; m_err = 1'b0; m_full = 1'b0; last_wd = '0;

    // ADD
    do_reset();
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h3ABCDEF);
    check("add_word", last_wd, 32'h0022_1820);

    // LW, BEQ, JAL, JR (nonzero rt/rd) filling the memory
    do_reset();
    send(4'd10, 5'd9, 5'd8, 5'd7, 16'h0004, 26'h1);
    check("lw_word", last_wd, 32'h8D28_0004);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    check("beq_word", last_wd, 32'h1022_FFFF);
    send(4'd12, 5'd3, 5'd4, 5'd5, 16'h5555, 26'h0000010);
    check("jal_word", last_wd, 32'h0C00_0010);
    send(4'd6, 5'd31, 5'd12, 5'd13, 16'hAAAA, 26'h3FFFFFF);
    check("jr_word", last_wd, 32'h03E0_0008);
    check("full_flag",  {31'b0, full}, 32'd1);
    check("full_count", {29'b0, count}, 32'd4);
    check("full_addr",  {30'b0, imem_addr}, 32'd0);

    // FULL is terminal: a held request is never accepted
    req_valid = 1'b1; req_kind = 4'd2;
    repeat (10) begin
      tick();
      check("full_hold_ready", {31'b0, req_ready}, 32'd0);
      check("full_hold_we",    {31'b0, imem_we}, 32'd0);
      check("full_hold_count", {29'b0, count}, 32'd4);
    end
    req_valid = 1'b0;

    // illegal kind, MUL, then fill
    do_reset();
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    check("illegal_err", {31'b0, err}, 32'd1);
    send(4'd5, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0);
`ifdef ENC_MUL_EN
    check("mul_word", last_wd, 32'h00A6_2018);
`else
    check("mul_count", {29'b0, count}, 32'd0);
`endif
    while (!m_full) send(4'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_err",  {31'b0, err}, 32'd1);

    // reset during WRITE drops the write
    do_reset();
    req_kind = 4'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("midrst_we_before", {31'b0, imem_we}, 32'd1);
    RST = 1'b1;
    #0;
    check("midrst_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("midrst_we",    {31'b0, imem_we}, 32'd0);
    check("midrst_count", {29'b0, count}, 32'd0);
    RST = 1'b0;
    tick();
    m_addr = 0; m_count = 0; m_err = 1'b0; m_full = 1'b0;
    check("midrst_addr", {30'b0, imem_addr}, 32'd0);
    check("midrst_wd",   imem_wd, 32'd0);
    check("midrst_err",  {31'b0, err}, 32'd0);
    send(4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < 10 && !m_full; k++) begin
        send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom));
      end
      check("rand_count", {29'b0, count}, 32'(m_count));
      check("rand_full",  {31'b0, full}, {31'b0, m_full});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_program_encoder.md
# imem_program_encoder

Sequential instruction encoder and loader that turns symbolic operation requests into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It produces exactly the opcode/funct encodings that the single-cycle control unit decodes. One request is accepted per valid/ready handshake. The block sits beside instruction memory as its program-load write port and is active before the processor is released from reset.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_kind  in  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6 JR, 7 ADDI, 8 BEQ, 9 SW, 10 LW, 11 J, 12 JAL; 13–15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate or branch offset, passed through unmodified.
- req_target  in  26  jump word target.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wd  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written.
- full  out  1  DEPTH words written.
- err  out  1  sticky flag: an illegal or compiled-out request was consumed.

## Operation
- **States:**
  - IDLE: req_ready=1.
  - WRITE: req_ready=0, imem_we=1.
  - FULL: req_ready=0, full=1.
- **Handshake:** a transfer occurs when req_valid && req_ready are both high at a rising edge. Request fields are sampled only at that edge.
- **Legal request in IDLE:**
  - The encoded word is registered into imem_wd, and the state moves to WRITE.
  - WRITE lasts one cycle. At its end, imem_addr and count increment.
  - The next state is FULL if count reaches DEPTH, otherwise IDLE.
- **Illegal request in IDLE:** err is set, nothing is written, addr and count are unchanged, and the state stays IDLE.
- **R-type encoding:** {6'b000000, rs, rt, rd, 5'b0, funct}.
  - funct values: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, MUL 011000, JR 001000.
  - For JR, rt and rd are forced to 0.
- **I-type encoding:** {op, rs, rt, imm}.
  - op values: ADDI 001000, BEQ 000100, SW 101011, LW 100011.
- **J-type encoding:** {op, target}.
  - op values: J 000010, JAL 000011.
- **Unused fields:** fields unused by a kind are forced to zero, never copied from the inputs.
- **FULL:** the state is terminal until RST; requests are never accepted and req_valid is ignored.
- **Address width:** imem_addr wraps to 0 after the final write, which occurs simultaneously with entry to FULL. count holds DEPTH.

## Timing
- **Reset values:** while RST is high and on the cycle after it falls:
  - state=IDLE
  - imem_we=0, imem_addr=0, imem_wd=0
  - count=0, full=0, err=0
  - req_ready=0 during any cycle with RST=1
- **Latency:** a request accepted at edge N drives imem_we=1 with its address and word during cycle N+1. req_ready returns high in cycle N+2 (when not full).
- **Throughput:** one word per 2 cycles.
- **Reset mid-operation:** RST high during WRITE drops that write. imem_we is 0 from the next cycle, and count is not incremented.
- **Reset/valid collision:** RST and req_valid high together means no transfer.
- **err:** set at the accept edge of the offending request; cleared only by RST.

## Configuration
- Macro ENC_MUL_EN.
- **Defined:** kind 5 encodes MUL (funct 011000) as a legal R-type.
- **Undefined:** kind 5 is illegal. It is consumed, err is set, and no write occurs.

## Test plan
- **ADD:** kind=2, rs=1, rt=2, rd=3 → next cycle imem_we=1, imem_addr=0, imem_wd=0x00221820; then count=1.
- **LW and BEQ:**
  - LW: kind=10, rs=9, rt=8, imm=0x0004 → imem_wd=0x8D280004 at addr 0.
  - Then BEQ: kind=8, rs=1, rt=2, imm=0xFFFF → imem_wd=0x1022FFFF at addr 1.
- **JAL:** kind=12, target=0x0000010 → imem_wd=0x0C000010. Also JR with nonzero rt/rd inputs, rs=31 → imem_wd=0x03E00008.
- **MUL:** kind=5, rs=5, rt=6, rd=4.
  - With ENC_MUL_EN: imem_wd=0x00A62018.
  - Without ENC_MUL_EN: err=1, imem_we stays 0, count=0.
- **Illegal kind and full:** ADDR_W=2.
  - Kind 15 → err=1, no write.
  - Then 4 legal requests → addresses 0..3 written; full=1, count=4, imem_addr=0, req_ready=0.
  - A 5th req_valid held for 10 cycles is never accepted.
- **Reset mid-write:** RST asserted in the WRITE cycle → all outputs at reset values, count=0, next request is written to addr 0.
